// File: rtl/ad9226_packet_reader.sv
// ad9226_packet_reader
// Pops one packed word of SAMPLES ADC samples from the sample FIFO, prefixes a
// 16-bit sequence number and streams the packet as bytes over valid/ready.
// Byte order: seq high, seq low, then each sample zero-extended to 16 bits,
// high byte first, sample 0 (oldest) first.

module ad9226_packet_reader #(
  parameter int ADC_BITS = 12,
  parameter int SAMPLES  = 20
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         fifo_empty,
  output logic                         fifo_read_enable,
  input  logic [ADC_BITS*SAMPLES-1:0]  fifo_data,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         tx_first,
  output logic                         tx_last,
  output logic [15:0]                  seq_num
);

  localparam int PKT_BYTES = 2 + 2 * SAMPLES;
  localparam int IDX_W     = (PKT_BYTES > 2) ? $clog2(PKT_BYTES) : 1;
  localparam int WORD_W    = ADC_BITS * SAMPLES;

  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         seq_q, seq_d;
  logic [WORD_W-1:0]   hold_q, hold_d;

  logic [15:0]         sample_s [SAMPLES];
  logic [7:0]          pkt_s    [PKT_BYTES];
  logic [7:0]          byte_s;
  logic                send_s;

  // State, byte index, sequence number and holding register flops.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_ZERO;
      seq_q   <= 16'h0000;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: pop in IDLE, capture in FETCH, walk the bytes in SEND.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    seq_d            = seq_q;
    hold_d           = hold_q;
    fifo_read_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_read_enable = 1'b1;
          state_d          = ST_FETCH;
        end else begin
          state_d          = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Normal-mode FIFO: data is valid the cycle after the pop strobe.
        hold_d  = fifo_data;
        idx_d   = IDX_ZERO;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (idx_q == IDX_LAST) begin
            seq_d   = seq_q + 16'd1;
            idx_d   = IDX_ZERO;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = IDX_ZERO;
      end
    endcase
  end

  // Unpack samples from the held word and zero-extend each to 16 bits.
  always_comb begin
    for (int k = 0; k < SAMPLES; k++) begin
      sample_s[k]               = 16'h0000;
      sample_s[k][ADC_BITS-1:0] = hold_q[ADC_BITS*k +: ADC_BITS];
    end
  end

  // Lay out the packet bytes in transmit order.
  always_comb begin
    pkt_s[0] = seq_q[15:8];
    pkt_s[1] = seq_q[7:0];
    for (int k = 0; k < SAMPLES; k++) begin
      pkt_s[2 + 2*k] = sample_s[k][15:8];
      pkt_s[3 + 2*k] = sample_s[k][7:0];
    end
  end

  // Select the byte addressed by the current index.
  always_comb begin
    byte_s = 8'h00;
    for (int b = 0; b < PKT_BYTES; b++) begin
      if (idx_q == IDX_W'(b)) begin
        byte_s = pkt_s[b];
      end else begin
        byte_s = byte_s;
      end
    end
  end

  // Output decode straight from the registered state; all zero outside SEND.
  always_comb begin
    send_s   = (state_q == ST_SEND);
    tx_valid = send_s;
    tx_data  = send_s ? byte_s : 8'h00;
    tx_first = send_s && (idx_q == IDX_ZERO);
    tx_last  = send_s && (idx_q == IDX_LAST);
    seq_num  = seq_q;
  end

endmodule

// File: tb/tb_ad9226_packet_reader.sv
// Bench for ad9226_packet_reader: FIFO model plus a byte-level packet reference.
`timescale 1ns/1ps

module tb_ad9226_packet_reader;

  localparam int ADC_BITS  = 12;
  localparam int SAMPLES   = 20;
  localparam int W         = ADC_BITS * SAMPLES;
  localparam int PKT_BYTES = 2 + 2 * SAMPLES;
  localparam int DEPTH     = 256;

  logic         clk;
  logic         reset_n;
  logic         fifo_empty;
  logic         fifo_read_enable;
  logic [W-1:0] fifo_data;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_first;
  logic         tx_last;
  logic [15:0]  seq_num;

  int errors;
  int checks;

  logic [W-1:0] mem [DEPTH];
  int           wr_cnt;
  int           rd_cnt;
  int           empty_pops;
  logic [15:0]  exp_seq;

  ad9226_packet_reader #(.ADC_BITS(ADC_BITS), .SAMPLES(SAMPLES)) dut (
    .sys_clk          (clk),
    .reset_n          (reset_n),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_data        (fifo_data),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_first         (tx_first),
    .tx_last          (tx_last),
    .seq_num          (seq_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (wr_cnt == rd_cnt);

  // Normal-mode FIFO model: data appears the cycle after the pop strobe.
  initial begin
    rd_cnt     = 0;
    empty_pops = 0;
    fifo_data  = '0;
  end
  always @(posedge clk) begin
    if (fifo_read_enable) begin
      if (wr_cnt == rd_cnt) begin
        empty_pops <= empty_pops + 1;
      end else begin
        fifo_data <= mem[rd_cnt % DEPTH];
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    mem[wr_cnt % DEPTH] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  function automatic logic [W-1:0] ramp_word();
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < SAMPLES; k++) w[ADC_BITS*k +: ADC_BITS] = ADC_BITS'(12'h100 + k);
    return w;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < SAMPLES; k++) w[ADC_BITS*k +: ADC_BITS] = ADC_BITS'($urandom);
    return w;
  endfunction

  // Receive one packet and compare every byte with the reference list.
  // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
  // exp_lat: negedges from call to first valid byte (-1 = not checked).
  // stop_at: byte index at which reset is asserted (-1 = none).
  task automatic recv_packet(input logic [W-1:0] word, input logic [15:0] seq,
                             input int mode, input int exp_lat, input int stop_at);
    logic [7:0]  exp_q [$];
    int unsigned sv;
    int idx, cyc, vcnt, first_cyc;
    logic r;
    exp_q.push_back(seq[15:8]);
    exp_q.push_back(seq[7:0]);
    for (int k = 0; k < SAMPLES; k++) begin
      sv = (word >> (ADC_BITS * k)) & ((1 << ADC_BITS) - 1);
      exp_q.push_back(8'(sv >> 8));
      exp_q.push_back(8'(sv));
    end
    idx = 0; cyc = 0; vcnt = 0; first_cyc = -1;
    while (idx < PKT_BYTES) begin
      @(negedge clk);
      cyc++;
      if (cyc > 2000) begin
        $display("FAIL timeout: byte %0d of seq %h never arrived", idx, seq);
        errors++; checks++;
        return;
      end
      if (tx_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (stop_at >= 0 && idx == stop_at) begin
          reset_n = 1'b0;
          #1;
          checks++;
          if (tx_valid !== 1'b0 || seq_num !== 16'h0000 || fifo_read_enable !== 1'b0) begin
            $display("FAIL mid_reset: valid=%b seq=%h rd_en=%b, required 0,0000,0",
                     tx_valid, seq_num, fifo_read_enable);
            errors++;
          end
          return;
        end
        checks++;
        if (tx_data !== exp_q[idx] || tx_first !== (idx == 0) ||
            tx_last !== (idx == PKT_BYTES - 1) || seq_num !== seq) begin
          $display("FAIL byte[%0d]: data=%h first=%b last=%b seq=%h, required %h %b %b %h",
                   idx, tx_data, tx_first, tx_last, seq_num, exp_q[idx],
                   (idx == 0), (idx == PKT_BYTES - 1), seq);
          errors++;
        end
        case (mode)
          0:       r = 1'b1;
          1:       r = (vcnt % 4 == 0) || (vcnt % 4 == 3);
          default: r = 1'($urandom);
        endcase
        vcnt++;
        tx_ready = r;
        if (r) idx++;
      end else begin
        if (tx_data !== 8'h00 || tx_first !== 1'b0 || tx_last !== 1'b0) begin
          $display("FAIL idle_outputs: data=%h first=%b last=%b, required 00 0 0",
                   tx_data, tx_first, tx_last);
          errors++;
        end
        checks++;
        tx_ready = 1'($urandom);
      end
    end
    checks++;
    if (exp_lat >= 0 && first_cyc !== exp_lat) begin
      $display("FAIL latency: first byte after %0d cycles, required %0d", first_cyc, exp_lat);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || seq_num !== seq + 16'd1) begin
      $display("FAIL post_packet: valid=%b seq=%h, required 0 %h", tx_valid, seq_num, seq + 16'd1);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    tx_ready = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0 || tx_first !== 1'b0 || tx_last !== 1'b0 ||
          tx_data !== 8'h00 || seq_num !== 16'h0000 || fifo_read_enable !== 1'b0) begin
        $display("FAIL reset_idle: valid=%b first=%b last=%b data=%h seq=%h rd_en=%b, required all 0",
                 tx_valid, tx_first, tx_last, tx_data, seq_num, fifo_read_enable);
        errors++;
      end
    end
    exp_seq = 16'h0000;
  endtask

  task automatic test_single();
    int pops0;
    logic [W-1:0] w;
    w = ramp_word();
    pops0 = rd_cnt;
    push_word(w);
    #1;
    checks++;
    if (fifo_read_enable !== 1'b1) begin
      $display("FAIL pop_strobe: rd_en=%b, required 1", fifo_read_enable);
      errors++;
    end
    recv_packet(w, exp_seq, 0, 2, -1);
    exp_seq = exp_seq + 16'd1;
    checks++;
    if (rd_cnt - pops0 !== 1) begin
      $display("FAIL single_pops: %0d pops, required 1", rd_cnt - pops0);
      errors++;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w;
    w = ramp_word();
    push_word(w);
    recv_packet(w, exp_seq, 1, 2, -1);
    exp_seq = exp_seq + 16'd1;
    w = rand_word();
    push_word(w);
    recv_packet(w, exp_seq, 2, 2, -1);
    exp_seq = exp_seq + 16'd1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ws [3];
    int pops0;
    pops0 = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      ws[i] = rand_word();
      push_word(ws[i]);
    end
    // Each packet ends with one idle negedge consumed inside recv_packet,
    // so a 2-cycle gap shows up as first byte on the 2nd negedge.
    for (int i = 0; i < 3; i++) begin
      recv_packet(ws[i], exp_seq, 0, 2, -1);
      exp_seq = exp_seq + 16'd1;
    end
    checks++;
    if (rd_cnt - pops0 !== 3) begin
      $display("FAIL b2b_pops: %0d pops, required 3", rd_cnt - pops0);
      errors++;
    end
  endtask

  task automatic test_seq_wrap();
    logic [W-1:0] w;
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    exp_seq = 16'hFFFF;
    w = rand_word();
    push_word(w);
    recv_packet(w, exp_seq, 0, 2, -1);
    exp_seq = exp_seq + 16'd1;
    w = rand_word();
    push_word(w);
    recv_packet(w, exp_seq, 2, 2, -1);
    exp_seq = exp_seq + 16'd1;
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] w;
    w = rand_word();
    push_word(w);
    recv_packet(w, exp_seq, 0, 2, 10);
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || seq_num !== 16'h0000) begin
      $display("FAIL in_reset: valid=%b seq=%h, required 0 0000", tx_valid, seq_num);
      errors++;
    end
    reset_n = 1'b1;
    exp_seq = 16'h0000;
    @(negedge clk);
    w = ramp_word();
    push_word(w);
    recv_packet(w, exp_seq, 0, 2, -1);
    exp_seq = exp_seq + 16'd1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    wr_cnt   = 0;
    reset_n  = 1'b0;
    tx_ready = 1'b0;
    exp_seq  = 16'h0000;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_seq_wrap();
    test_mid_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (empty_pops !== 0) begin
      $display("FAIL empty_pop: %0d pops while empty, required 0", empty_pops);
      errors++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad9226_packet_reader.md
# ad9226_packet_reader

Drain side of the AD9226 sample FIFO. Pops one packed word of SAMPLES ADC samples, prefixes a 16-bit sequence number, and streams the result as bytes over a valid/ready handshake to the W5500 TX path. It mirrors the packer that writes the FIFO: same packing order, same word width, same clock domain.

## Interface
- ADC_BITS, 12, sample width in bits; legal range 1..16.
- SAMPLES, 20, samples per FIFO word and per packet.
- sys_clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO has no words.
- fifo_read_enable  out  1  one-cycle pop strobe to the FIFO (normal mode, not show-ahead).
- fifo_data  in  ADC_BITS*SAMPLES  FIFO read data; valid the cycle after fifo_read_enable.
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts the byte when tx_valid && tx_ready.
- tx_first  out  1  high with the first byte of a packet.
- tx_last  out  1  high with the last byte of a packet.
- seq_num  out  16  sequence number of the packet currently being sent, or of the next packet.

## Operation
- Packing: sample k (k = 0 first in time) is fifo_data[ADC_BITS*k +: ADC_BITS].
- Packet: PKT_BYTES = 2 + 2*SAMPLES, which is 42 at defaults. Byte order:
  - seq_num[15:8], then seq_num[7:0];
  - then, for k = 0..SAMPLES-1, the sample zero-extended to 16 bits, high byte then low byte.
- States:
  - IDLE: outputs idle. If !fifo_empty, assert fifo_read_enable for one cycle and go to FETCH.
  - FETCH: one wait cycle. At the end of this cycle, capture fifo_data into the holding register. Go to SEND with byte index 0.
  - SEND: present byte[index] with tx_valid=1. On each accept, index increments. On accepting index PKT_BYTES-1, increment seq_num (mod 2^16, 0xFFFF wraps to 0x0000) and go to IDLE.
- tx_data, tx_first, tx_last and the holding register are stable while tx_valid && !tx_ready.
- tx_first=1 iff index=0; tx_last=1 iff index=PKT_BYTES-1. Both are 0 when tx_valid=0.
- fifo_empty is sampled only in IDLE. fifo_read_enable is never asserted outside IDLE, and never while fifo_empty=1. No underflow is possible.
- The byte index counter is wide enough for PKT_BYTES-1 (6 bits at defaults).

## Timing
- Reset values: fifo_read_enable=0, tx_valid=0, tx_first=0, tx_last=0, tx_data=0, seq_num=0. State is IDLE and the holding register is 0.
- Reset asserted mid-packet: the packet is aborted immediately with no further bytes and seq_num returns to 0. The FIFO word being sent is lost; this is accepted.
- Latency, with cycle N being the IDLE cycle where fifo_empty=0:
  - fifo_read_enable=1 in N;
  - FETCH in N+1;
  - tx_valid=1 with tx_first and the seq_num high byte in N+2.
- With tx_ready held high, one byte per cycle. A full packet occupies cycles N+2 .. N+2+PKT_BYTES-1.
- The cycle after the last accept is IDLE. Back-to-back packets therefore have a 2-cycle gap with tx_valid=0: IDLE plus FETCH.
- seq_num updates on the edge where the last byte is accepted. It is constant for the whole packet.
- tx_ready is ignored while tx_valid=0.

## Test plan
- Reset/idle: reset_n=0 for 10 cycles, fifo_empty=1 after release -> all outputs 0, fifo_read_enable never asserted.
- Single packet, ready always high: one word with sample k = 12'h100+k -> 42 bytes 00,00,01,00,01,01,...,01,13. tx_first on byte 0, tx_last on byte 41, seq_num then reads 1, exactly one fifo_read_enable pulse.
- Backpressure: same word, tx_ready toggling 1,0,0,1 repeatedly -> identical byte sequence. tx_data/tx_first/tx_last stable during stalls. No byte duplicated or skipped.
- Back-to-back: three words queued, fifo_empty low throughout -> packets with seq 0,1,2. Exactly 2 idle cycles between the last byte of one packet and the first byte of the next. Three pops total.
- Sequence wrap: run 65537 packets, or preload via force -> the packet after seq 0xFFFF carries 0x0000.
- Reset mid-packet: assert reset_n=0 at byte 10 of packet 3 -> tx_valid drops asynchronously and seq_num=0. The next packet after release starts with bytes 00,00 and tx_first.
